arp_query_arbiter: RTL and testbench

Shares the single `arp_cache` query port between `NUM_REQ` requesters (forwarding, health-check and ARP-reply paths) inside `lb_dataplane`. Requests are granted round-robin and forwarded to the cache. The granted requester index is queued in an in-order tag FIFO, and each cache response is routed back to the requester at the FIFO head. Up to `MAX_OUTSTANDING` queries may be in flight.

---
 rtl/lb_pkg.sv | 19 +
 rtl/lb_tag_fifo.sv | 56 +++++
 rtl/arp_query_arbiter.sv | 144 ++++++++++++++
 tb/tb_arp_query_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared widths and helpers for the load-balancer dataplane blocks.
//   IP_W  : IPv4 address width
//   MAC_W : Ethernet MAC width
//   clog2 : ceiling log2, clog2(1) = 0
package lb_pkg;

    localparam int unsigned IP_W  = 32;
    localparam int unsigned MAC_W = 48;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/lb_tag_fifo.sv
// In-order synchronous FIFO holding requester tags for outstanding queries.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_push/i_data : write a tag (ignored when full)
//   i_pop         : drop the head tag (ignored when empty)
//   o_full/o_empty: occupancy flags
//   o_count       : number of stored tags (0..DEPTH)
//   o_head        : tag at the head, valid when !o_empty
module lb_tag_fifo
    import lb_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]        o_head
);

    localparam int unsigned AW = clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (i_pop && !o_empty) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count = r_wptr - r_rptr;
    assign o_head  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/arp_query_arbiter.sv
// Shares one arp_cache query port among NUM_REQ requesters. Requests are
// granted round-robin (with a lock that holds a stalled grant), the granted
// index is queued in an in-order tag FIFO, and cache responses are routed to
// the requester at the FIFO head.
// Ports:
//   clk, rst                              : clock, async active-high reset
//   req_valid_i/req_ready_o/req_ip_i      : requester query handshakes + IPs
//   resp_valid_o/resp_ready_i             : per-requester response handshakes
//   resp_mac_o/resp_err_o                 : shared response payload
//   cache_req_valid_o/cache_req_ready_i   : query handshake to the cache
//   cache_ip_o                            : IP of the granted requester
//   cache_resp_valid_i/cache_resp_ready_o : response handshake from the cache
//   cache_mac_i/cache_err_i               : cache response payload
//   inflight_o                            : outstanding query count
//   orphan_o                              : sticky, response seen with nothing outstanding
module arp_query_arbiter
    import lb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [IP_W*NUM_REQ-1:0]         req_ip_i,
    output logic [NUM_REQ-1:0]              resp_valid_o,
    input  logic [NUM_REQ-1:0]              resp_ready_i,
    output logic [MAC_W-1:0]                resp_mac_o,
    output logic                            resp_err_o,
    output logic                            cache_req_valid_o,
    input  logic                            cache_req_ready_i,
    output logic [IP_W-1:0]                 cache_ip_o,
    input  logic                            cache_resp_valid_i,
    output logic                            cache_resp_ready_o,
    input  logic [MAC_W-1:0]                cache_mac_i,
    input  logic                            cache_err_i,
    output logic [clog2(MAX_OUTSTANDING):0] inflight_o,
    output logic                            orphan_o
);

    localparam int unsigned TAG_W = clog2(NUM_REQ);
    localparam int unsigned CNT_W = clog2(MAX_OUTSTANDING) + 1;

    logic [TAG_W-1:0] r_rr;
    logic             r_lock;
    logic [TAG_W-1:0] r_lock_g;
    logic             r_orphan;

    logic [TAG_W-1:0] w_search;
    logic             w_found;
    int unsigned      w_idx;
    logic [TAG_W-1:0] w_g;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [TAG_W-1:0] w_head;
    logic             w_head_ready;
    logic             w_cvalid;
    logic             w_req_fire;
    logic             w_resp_fire;

    // Round-robin search: first valid requester at or after r_rr.
    always_comb begin
        w_search = r_rr;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_idx = (32'(r_rr) + 32'(i)) % NUM_REQ;
            if (!w_found && req_valid_i[TAG_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_search = TAG_W'(w_idx);
            end
        end
    end

    // A stalled request keeps its grant until it transfers.
    assign w_g         = r_lock ? r_lock_g : w_search;
    assign w_cvalid    = (|req_valid_i) & ~w_full;
    assign w_req_fire  = w_cvalid & cache_req_ready_i;
    assign w_resp_fire = cache_resp_valid_i & ~w_empty & w_head_ready;

    // Per-requester steering of grant and response; all outputs zero in reset.
    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        cache_ip_o   = '0;
        w_head_ready = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (w_g == TAG_W'(k)) begin
                req_ready_o[k] = cache_req_ready_i & ~w_full & ~rst;
                cache_ip_o     = rst ? '0 : req_ip_i[k*IP_W +: IP_W];
            end
            if (w_head == TAG_W'(k)) begin
                resp_valid_o[k] = cache_resp_valid_i & ~w_empty & ~rst;
                w_head_ready    = resp_ready_i[k];
            end
        end
    end

    assign cache_req_valid_o  = w_cvalid & ~rst;
    assign cache_resp_ready_o = w_head_ready & ~w_empty & ~rst;
    assign resp_mac_o         = rst ? '0 : cache_mac_i;
    assign resp_err_o         = cache_err_i & ~rst;
    assign inflight_o         = rst ? '0 : w_count;
    assign orphan_o           = r_orphan;

    // Arbiter pointer, grant lock and orphan flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr     <= '0;
            r_lock   <= 1'b0;
            r_lock_g <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_rr   <= (w_g == TAG_W'(NUM_REQ - 1)) ? '0 : w_g + TAG_W'(1);
                r_lock <= 1'b0;
            end else if (w_cvalid && !cache_req_ready_i) begin
                r_lock   <= 1'b1;
                r_lock_g <= w_g;
            end
            if (cache_resp_valid_i && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    lb_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_req_fire),
        .i_data  (w_g),
        .i_pop   (w_resp_fire),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_arp_query_arbiter.sv
// Bench for arp_query_arbiter: directed scenarios plus a randomized phase,
// all checked against a queue-based reference model of the arbiter.
module tb_arp_query_arbiter;

    localparam int unsigned N = 2;
    localparam int unsigned M = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid_i;
    logic [N-1:0]     req_ready_o;
    logic [32*N-1:0]  req_ip_i;
    logic [N-1:0]     resp_valid_o;
    logic [N-1:0]     resp_ready_i;
    logic [47:0]      resp_mac_o;
    logic             resp_err_o;
    logic             cache_req_valid_o;
    logic             cache_req_ready_i;
    logic [31:0]      cache_ip_o;
    logic             cache_resp_valid_i;
    logic             cache_resp_ready_o;
    logic [47:0]      cache_mac_i;
    logic             cache_err_i;
    logic [2:0]       inflight_o;
    logic             orphan_o;

    always #5 clk = ~clk;

    arp_query_arbiter #(
        .NUM_REQ         (N),
        .MAX_OUTSTANDING (M)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_ip_i           (req_ip_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_mac_o         (resp_mac_o),
        .resp_err_o         (resp_err_o),
        .cache_req_valid_o  (cache_req_valid_o),
        .cache_req_ready_i  (cache_req_ready_i),
        .cache_ip_o         (cache_ip_o),
        .cache_resp_valid_i (cache_resp_valid_i),
        .cache_resp_ready_o (cache_resp_ready_o),
        .cache_mac_i        (cache_mac_i),
        .cache_err_i        (cache_err_i),
        .inflight_o         (inflight_o),
        .orphan_o           (orphan_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: priority pointer, lock, ordered tag queue, orphan flag.
    int          m_rr;
    bit          m_lock;
    int          m_lock_g;
    int          m_tags[$];
    bit          m_orphan;
    logic [31:0] pend[$];

    // Stimulus state (requesters and cache).
    bit [N-1:0]  v_req;
    logic [31:0] v_ip [N];
    bit          v_cready;
    bit          v_crv;
    logic [47:0] v_mac;
    bit          v_err;
    bit [N-1:0]  v_rready;
    int          req_mode;    // 0 manual, 1 random
    int          cache_mode;  // 0 manual, 1 always respond, 2 random

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lock_g = 0; m_orphan = 0;
        m_tags.delete();
        pend.delete();
    endtask

    task automatic clear_stim();
        v_req = '0; v_cready = 0; v_crv = 0; v_mac = '0; v_err = 0; v_rready = '0;
        for (int k = 0; k < int'(N); k++) v_ip[k] = '0;
        req_mode = 0; cache_mode = 0;
    endtask

    task automatic drive();
        req_valid_i = v_req;
        for (int k = 0; k < int'(N); k++) req_ip_i[k*32 +: 32] = v_ip[k];
        cache_req_ready_i  = v_cready;
        cache_resp_valid_i = v_crv;
        cache_mac_i        = v_mac;
        cache_err_i        = v_err;
        resp_ready_i       = v_rready;
    endtask

    // One clock cycle: generate stimulus, compare against the model, advance.
    task automatic step();
        int g; int h; bit full; bit empty; bit found; bit cv; bit rf; bit pf;
        logic [N-1:0] e_ready; logic [N-1:0] e_rvalid; bit e_crr;
        if (req_mode == 1) begin
            for (int k = 0; k < int'(N); k++) begin
                if (!v_req[k] && $urandom_range(0, 2) != 0) begin
                    v_req[k] = 1'b1;
                    v_ip[k]  = $urandom;
                end
            end
            v_cready = ($urandom_range(0, 3) != 0);
        end
        if (cache_mode != 0 && !v_crv && pend.size() > 0 &&
            (cache_mode == 1 || $urandom_range(0, 1) == 1)) begin
            v_crv = 1'b1;
            v_mac = {16'h0200, pend[0]};
            v_err = ($urandom_range(0, 3) == 0);
        end
        if (cache_mode == 1) v_rready = '1;
        else if (cache_mode == 2) begin
            for (int k = 0; k < int'(N); k++) v_rready[k] = ($urandom_range(0, 3) != 0);
        end
        drive();
        #2;
        full  = (m_tags.size() == int'(M));
        empty = (m_tags.size() == 0);
        found = 0;
        g     = m_rr;
        if (m_lock) g = m_lock_g;
        else begin
            for (int i = 0; i < int'(N); i++) begin
                if (!found && v_req[(m_rr + i) % int'(N)]) begin
                    found = 1;
                    g     = (m_rr + i) % int'(N);
                end
            end
        end
        cv      = (v_req != '0) && !full;
        e_ready = '0;
        if (v_cready && !full) e_ready[g] = 1'b1;
        h        = empty ? 0 : m_tags[0];
        e_rvalid = '0;
        if (v_crv && !empty) e_rvalid[h] = 1'b1;
        e_crr = !empty && v_rready[h];
        check("cache_req_valid", cache_req_valid_o, cv);
        check("req_ready", req_ready_o, e_ready);
        if (cv) check("cache_ip", cache_ip_o, v_ip[g]);
        check("resp_valid", resp_valid_o, e_rvalid);
        check("cache_resp_ready", cache_resp_ready_o, e_crr);
        if (v_crv) begin
            check("resp_mac", resp_mac_o, v_mac);
            check("resp_err", resp_err_o, v_err);
        end
        check("inflight", inflight_o, m_tags.size());
        check("orphan", orphan_o, m_orphan);
        rf = cv && v_cready;
        pf = v_crv && !empty && v_rready[h];
        if (rf) begin
            m_tags.push_back(g);
            pend.push_back(v_ip[g]);
            m_rr   = (g + 1) % int'(N);
            m_lock = 0;
        end else if (cv) begin
            m_lock   = 1;
            m_lock_g = g;
        end
        if (pf) begin
            void'(m_tags.pop_front());
            void'(pend.pop_front());
        end
        if (v_crv && empty) m_orphan = 1;
        if (rf) v_req[g] = 1'b0;
        if (pf) v_crv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 0);
        check({tag, "_resp_valid"}, resp_valid_o, 0);
        check({tag, "_resp_mac"}, resp_mac_o, 0);
        check({tag, "_resp_err"}, resp_err_o, 0);
        check({tag, "_cache_req_valid"}, cache_req_valid_o, 0);
        check({tag, "_cache_ip"}, cache_ip_o, 0);
        check({tag, "_cache_resp_ready"}, cache_resp_ready_o, 0);
        check({tag, "_inflight"}, inflight_o, 0);
        check({tag, "_orphan"}, orphan_o, 0);
    endtask

    task automatic drain(input string tag);
        int n;
        req_mode = 0; cache_mode = 1; v_cready = 1;
        n = 0;
        while ((m_tags.size() != 0 || v_req != '0) && n < 60) begin
            step();
            n++;
        end
        check({tag, "_drained"}, (m_tags.size() == 0 && v_req == '0), 1);
        cache_mode = 0;
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] exp_route [4];
        exp_route[0] = 2'b01; exp_route[1] = 2'b10; exp_route[2] = 2'b10; exp_route[3] = 2'b01;

        // Reset with busy inputs: every output must read zero.
        clear_stim();
        v_req = '1; v_cready = 1; v_crv = 1; v_mac = 48'hABCDEF012345; v_err = 1; v_rready = '1;
        v_ip[0] = 32'h01020304; v_ip[1] = 32'h05060708;
        rst = 1'b1;
        drive();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        clear_stim();
        drive();
        rst = 1'b0;
        model_reset();

        // Single request from requester 0, cache answers two cycles later.
        v_req = 2'b01; v_ip[0] = 32'h0A000001; v_cready = 1;
        step();
        check("single_inflight1", inflight_o, 1);
        step();
        step();
        v_crv = 1; v_mac = 48'h020000000001; v_err = 0; v_rready = 2'b11;
        drive();
        #1;
        check("single_resp_valid", resp_valid_o, 2'b01);
        check("single_resp_mac", resp_mac_o, 48'h020000000001);
        step();
        step();
        check("single_inflight0", inflight_o, 0);

        // Fairness: both requesters held valid, grants alternate starting at 1.
        cache_mode = 1;
        for (int i = 0; i < 8; i++) begin
            v_req = 2'b11; v_ip[0] = $urandom; v_ip[1] = $urandom; v_cready = 1;
            drive();
            #1;
            check("fair_grant", req_ready_o, (i % 2 == 0) ? 2'b10 : 2'b01);
            step();
        end
        v_req = '0;
        drain("fair");

        // Lock: requester 1 stalls, requester 0 arrives, grant stays on 1.
        v_req = 2'b10; v_ip[1] = 32'hC0A80102; v_cready = 0;
        step();
        v_req = 2'b11; v_ip[0] = 32'hC0A80101;
        for (int i = 0; i < 2; i++) begin
            drive();
            #1;
            check("lock_ip", cache_ip_o, 32'hC0A80102);
            step();
        end
        v_cready = 1;
        drive();
        #1;
        check("lock_release", req_ready_o, 2'b10);
        step();
        drive();
        #1;
        check("lock_next", req_ready_o, 2'b01);
        step();
        drain("lock");

        // Ordering: fill with 0,1,1,0, fifth stalls, responses route in order.
        v_cready = 1;
        for (int i = 0; i < 4; i++) begin
            v_req = exp_route[i];
            v_ip[(exp_route[i] == 2'b01) ? 0 : 1] = 32'h0A0A0000 + 32'(i);
            step();
        end
        v_req = 2'b01; v_ip[0] = 32'h0A0A0099;
        drive();
        #1;
        check("full_ready", req_ready_o, 0);
        check("full_cvalid", cache_req_valid_o, 0);
        check("full_inflight", inflight_o, 4);
        step();
        for (int i = 0; i < 4; i++) begin
            v_crv = 1; v_mac = 48'h020000000010 + 48'(i); v_err = (i == 2); v_rready = 2'b11;
            drive();
            #1;
            check("order_route", resp_valid_o, exp_route[i]);
            check("order_err", resp_err_o, (i == 2));
            step();
        end
        drain("order");

        // Back-pressure: head requester not ready, nothing pops.
        v_req = 2'b01; v_ip[0] = 32'h0B000001; v_cready = 1;
        step();
        step();
        v_crv = 1; v_mac = 48'h0200000000BB; v_err = 0; v_rready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            drive();
            #1;
            check("bp_cache_resp_ready", cache_resp_ready_o, 0);
            check("bp_inflight", inflight_o, 1);
            step();
        end
        v_rready = 2'b01;
        step();
        step();
        check("bp_done_inflight", inflight_o, 0);

        // Randomized traffic against the model.
        req_mode = 1; cache_mode = 2;
        for (int i = 0; i < 400; i++) step();
        drain("random");

        // Orphan response while nothing is outstanding.
        v_crv = 1; v_mac = 48'h0200000000EE; v_err = 0; v_rready = 2'b11;
        step();
        v_crv = 0;
        step();
        check("orphan_set", orphan_o, 1);

        // Reset mid-burst with two queries outstanding.
        v_cready = 1;
        v_req = 2'b01; v_ip[0] = 32'h0C000001;
        step();
        v_req = 2'b10; v_ip[1] = 32'h0C000002;
        step();
        check("burst_inflight", inflight_o, 2);
        v_req = 2'b11; v_crv = 1; v_mac = 48'h0200000000CC; v_rready = 2'b11;
        drive();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_stim();
        v_req = 2'b11; v_ip[0] = 32'h0D000001; v_ip[1] = 32'h0D000002; v_cready = 1;
        drive();
        #1;
        check("post_reset_inflight", inflight_o, 0);
        check("post_reset_grant", req_ready_o, 2'b01);
        step();
        step();
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
